// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: rounded bit-period calculation, framing levels
// and receiver state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Clock cycles per bit, rounded to nearest; 64-bit math avoids overflow
  function automatic int unsigned bit_cycles(input int unsigned sys_clock,
                                             input int unsigned baud);
    longint unsigned r;
    r = (64'(sys_clock) * 64'd10 / 64'(baud) + 64'd5) / 64'd10;
    return r[31:0];
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with previous-value flop, falling-edge detect and the
// sample value used by the receiver. UART_RX_MAJORITY_EN adds a 2-of-3 vote.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_serial,
  output logic o_fall,
  output logic o_sample
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = i_serial;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_fall = prev_q & ~sync_q;

`ifdef UART_RX_MAJORITY_EN
  logic prev2_q, prev2_d;

  always_comb prev2_d = prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev2_q <= IDLE_LEVEL;
    else     prev2_q <= prev2_d;
  end

  assign o_sample = (sync_q & prev_q) | (sync_q & prev2_q) | (prev_q & prev2_q);
`else
  assign o_sample = sync_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled on the system clock.
// Optional UART_RX_MAJORITY_EN selects 2-of-3 voting at every sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLOCK     = 50000000,
  parameter int unsigned UART_BAUDRATE = 115200
) (
  input  logic       i_SysClock,
  input  logic       i_Reset,
  input  logic       i_RxSerial,
  output logic [7:0] o_RxByte,
  output logic       o_RxValid,
  output logic       o_RxFrameErr,
  output logic       o_RxBusy
);

  localparam int unsigned BIT_CYCLES    = bit_cycles(SYS_CLOCK, UART_BAUDRATE);
  localparam int unsigned MAX_CYCLE_CNT = BIT_CYCLES - 1;
  localparam int unsigned HALF_CNT      = MAX_CYCLE_CNT / 2;
  localparam int unsigned CNT_W         = $clog2(MAX_CYCLE_CNT) + 1;
  localparam int unsigned BIT_W         = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLE_CNT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic fall;
  logic sample;

  uart_rx_sync u_sync (
    .clk      (i_SysClock),
    .rst      (i_Reset),
    .i_serial (i_RxSerial),
    .o_fall   (fall),
    .o_sample (sample)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          // A high mid-start sample was a glitch: drop back without output
          state_d   = (sample == 1'b0) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d     = '0;
          shift_d   = {sample, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sample == STOP_LEVEL) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_SysClock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign o_RxByte     = byte_q;
  assign o_RxValid    = valid_q;
  assign o_RxFrameErr = err_q;
  assign o_RxBusy     = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a 10-cycle/bit receiver checked every cycle
// against a frame-level expectation queue, plus a 20-cycle/bit receiver for
// baud-mismatch frames.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx1, rx2;
  logic [7:0] byte1, byte2;
  logic       valid1, err1, busy1;
  logic       valid2, err2, busy2;

  always #5 clk = ~clk;

  uart_rx #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000)) dut (
    .i_SysClock   (clk),
    .i_Reset      (rst),
    .i_RxSerial   (rx1),
    .o_RxByte     (byte1),
    .o_RxValid    (valid1),
    .o_RxFrameErr (err1),
    .o_RxBusy     (busy1)
  );

  uart_rx #(.SYS_CLOCK(2000000), .UART_BAUDRATE(100000)) dut20 (
    .i_SysClock   (clk),
    .i_Reset      (rst),
    .i_RxSerial   (rx2),
    .o_RxByte     (byte2),
    .o_RxValid    (valid2),
    .o_RxFrameErr (err2),
    .o_RxBusy     (busy2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome of each transmitted frame, in order
  typedef struct {
    logic       is_err;
    logic [7:0] data;
    time        t0;
  } exp_t;

  exp_t       expq[$];
  exp_t       e_cur;
  logic [7:0] model_byte = 8'h00;
  logic       pulse_prev = 1'b0;
  longint     lat;

  always @(negedge clk) begin
    if (rst) begin
      model_byte = 8'h00;
      pulse_prev = 1'b0;
      check("reset_outputs", {byte1, valid1, err1, busy1}, 0);
    end else begin
      check("pulse_exclusive", longint'(valid1 & err1), 0);
      check("pulse_spacing", longint'(pulse_prev & (valid1 | err1)), 0);
      if (valid1 | err1) begin
        if (expq.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e_cur = expq.pop_front();
          check("pulse_kind_is_err", longint'(err1), longint'(e_cur.is_err));
          lat = longint'(($time - e_cur.t0) / 10);
          check("latency_93_100", longint'(lat >= 93 && lat <= 100), 1);
          if (!e_cur.is_err) model_byte = e_cur.data;
        end
      end
      check("rx_byte", byte1, model_byte);
      pulse_prev = valid1 | err1;
    end
  end

  int valid2_cnt = 0;
  int err2_cnt   = 0;
  logic [7:0] last2 = 8'h00;

  always @(negedge clk) begin
    if (valid2) begin
      valid2_cnt++;
      last2 = byte2;
    end
    if (err2) err2_cnt++;
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx1 = v;
  endtask

  // One 8N1 frame with bit period 'per' time units; sel=0 feeds the checked DUT
  task automatic send(input bit sel, input logic [7:0] d, input bit bad_stop,
                      input int per);
    time t0;
    t0 = $time;
    if (!sel) expq.push_back('{is_err: bad_stop, data: d, t0: t0});
    drive(sel, 1'b0);
    #(per);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      #(per);
      if (!sel && i == 3) check("busy_mid_frame", longint'(busy1), 1);
    end
    drive(sel, ~bad_stop);
    #(per);
    drive(sel, 1'b1);
  endtask

  task automatic idle(input int cycles);
    #(cycles * 10);
  endtask

  task automatic dut2_frame(input logic [7:0] d, input int per);
    int v0, e0;
    v0 = valid2_cnt;
    e0 = err2_cnt;
    @(negedge clk);
    send(1'b1, d, 1'b0, per);
    idle(40);
    check("baud_valid_count", valid2_cnt - v0, 1);
    check("baud_err_count", err2_cnt - e0, 0);
    check("baud_byte", last2, d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] rd;
  bit         rbs;
  int         rgap;
  logic [7:0] abort_byte;

  initial begin
    rst = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", longint'(busy1), 0);

    // Single frame at exact baud
    send(1'b0, 8'hA5, 1'b0, 100);
    idle(20);
    check("t1_byte", byte1, 8'hA5);

    // Back-to-back frames, no idle between
    @(negedge clk);
    send(1'b0, 8'h00, 1'b0, 100);
    send(1'b0, 8'hFF, 1'b0, 100);
    send(1'b0, 8'h3C, 1'b0, 100);
    idle(20);
    check("t2_last_byte", byte1, 8'h3C);

    // Stop bit low, then line held low before releasing
    @(negedge clk);
    send(1'b0, 8'h55, 1'b1, 100);
    rx1 = 1'b0;
    idle(50);
    rx1 = 1'b1;
    idle(30);
    check("t3_byte_kept", byte1, 8'h3C);
    check("t3_idle_busy", longint'(busy1), 0);

    // 3-cycle low glitch on idle line, then a real frame
    @(negedge clk);
    rx1 = 1'b0;
    idle(3);
    rx1 = 1'b1;
    idle(20);
    check("t4_glitch_busy", longint'(busy1), 0);
    send(1'b0, 8'h81, 1'b0, 100);
    idle(20);
    check("t4_byte", byte1, 8'h81);

    // Reset in the middle of bit 4 of 0x12; transmitter abandons the frame
    @(negedge clk);
    abort_byte = 8'h12;
    rx1 = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      rx1 = abort_byte[i];
      #100;
    end
    rx1 = abort_byte[4];
    #52;
    rst = 1'b1;
    #10;
    rst = 1'b0;
    rx1 = 1'b1;
    @(negedge clk);
    idle(30);
    check("t5_byte_after_reset", byte1, 8'h00);
    check("t5_busy_after_reset", longint'(busy1), 0);
    send(1'b0, 8'h34, 1'b0, 100);
    idle(20);
    check("t5_byte", byte1, 8'h34);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted glitch on the line sampled for data bit 2
    @(negedge clk);
    fork
      send(1'b0, 8'h5A, 1'b0, 100);
      begin
        #350;
        rx1 = ~rx1;
        #10;
        rx1 = ~rx1;
      end
    join
    idle(20);
    check("maj_glitch_byte", byte1, 8'h5A);
`endif

    // Random frames with random gaps and occasional bad stop bits
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      rd   = 8'($urandom);
      rbs  = ($urandom_range(0, 7) == 0);
      rgap = $urandom_range(0, 15);
      send(1'b0, rd, rbs, 100);
      if (rbs && rgap < 3) rgap = 3;
      idle(rgap);
    end
    idle(30);

    // 20-cycle receiver with transmitter 4% fast and 4% slow
    dut2_frame(8'hC3, 192);
    dut2_frame(8'hC3, 208);
    for (int n = 0; n < 4; n++) dut2_frame(8'($urandom), (n % 2 == 0) ? 192 : 208);

    idle(20);
    check("all_frames_seen", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
